// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM access controller and its lane aligner.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_B   = 2'b00,
        MEM_H   = 2'b01,
        MEM_W   = 2'b10,
        MEM_ILL = 2'b11
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RWAIT = 3'd3,
        RESP  = 3'd4
    } ctrl_state_e;

    localparam logic [3:0] LANE_B0      = 4'b0001;
    localparam logic [3:0] LANE_LO_HALF = 4'b0011;
    localparam logic [3:0] LANE_HI_HALF = 4'b1100;
    localparam logic [3:0] LANE_ALL     = 4'b1111;

    // Illegal size or offset not naturally aligned to the access size.
    function automatic logic size_align_error(input mem_size_e size, input logic [1:0] off);
        logic err;
        case (size)
            MEM_B:   err = 1'b0;
            MEM_H:   err = off[0];
            MEM_W:   err = |off;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/sram_lane_align.sv
// Combinational byte-lane steering for stores and shift/extend alignment for loads.
module sram_lane_align
    import sram_ctrl_pkg::*;
(
    input  mem_size_e   st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_data,
    output logic [3:0]  st_byte_sel,
    input  mem_size_e   ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] shifted_s;

    // Store side: replicate the datum across lanes and enable only the addressed ones.
    always_comb begin
        st_data     = st_wdata;
        st_byte_sel = LANE_ALL;
        case (st_size)
            MEM_B: begin
                st_data     = {4{st_wdata[7:0]}};
                st_byte_sel = LANE_B0 << st_off;
            end
            MEM_H: begin
                st_data     = {2{st_wdata[15:0]}};
                st_byte_sel = st_off[1] ? LANE_HI_HALF : LANE_LO_HALF;
            end
            MEM_W: begin
                st_data     = st_wdata;
                st_byte_sel = LANE_ALL;
            end
            default: begin
                st_data     = st_wdata;
                st_byte_sel = LANE_ALL;
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then sign/zero extend.
    always_comb begin
        shifted_s = ld_word >> {ld_off, 3'b000};
        ld_data   = shifted_s;
        case (ld_size)
            MEM_B:   ld_data = {{24{~ld_unsigned & shifted_s[7]}}, shifted_s[7:0]};
            MEM_H:   ld_data = {{16{~ld_unsigned & shifted_s[15]}}, shifted_s[15:0]};
            MEM_W:   ld_data = shifted_s;
            default: ld_data = shifted_s;
        endcase
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-outstanding load/store initiator for a single-port SRAM macro.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] sram_addr_sel,
    output logic [3:0]            sram_byte_sel,
    output logic                  sram_read_enable,
    output logic                  sram_write_enable,
    output logic [DATA_WIDTH-1:0] sram_datain,
    input  logic [DATA_WIDTH-1:0] sram_dataout
);

    ctrl_state_e           state_r, state_next_s;
    mem_size_e             req_size_s, size_r;
    logic [1:0]            off_r;
    logic                  uns_r, err_r;
    logic [1:0]            cnt_r;
    logic                  accept_s, range_err_s, req_err_s, rsp_valid_next_s;
    logic [31:0]           st_data_s, ld_data_s, rdata_cap_r;
    logic [3:0]            st_byte_sel_s;
    logic                  req_ready_r, rsp_valid_r, rsp_err_r;
    logic [31:0]           rsp_rdata_r;
    logic [ADDR_WIDTH-1:0] addr_sel_r;
    logic [3:0]            byte_sel_r;
    logic                  rd_en_r, wr_en_r;
    logic [31:0]           datain_r;

    assign req_size_s  = mem_size_e'(req_size);
    assign accept_s    = req_valid & req_ready_r & (state_r == IDLE);
    assign range_err_s = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign req_err_s   = range_err_s | size_align_error(req_size_s, req_addr[1:0]);
    // The response becomes visible one cycle into RESP and drops on the handshake edge.
    assign rsp_valid_next_s = (state_r == RESP) && (state_next_s == RESP);

    sram_lane_align u_align (
        .st_size     (req_size_s),
        .st_off      (req_addr[1:0]),
        .st_wdata    (req_wdata),
        .st_data     (st_data_s),
        .st_byte_sel (st_byte_sel_s),
        .ld_size     (size_r),
        .ld_off      (off_r),
        .ld_unsigned (uns_r),
        .ld_word     (sram_dataout),
        .ld_data     (ld_data_s)
    );

    // Next-state decode for the transaction FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_err_s) begin
                        state_next_s = RESP;
                    end else if (req_we) begin
                        state_next_s = WR;
                    end else begin
                        state_next_s = RD;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WR:    state_next_s = RESP;
            RD:    state_next_s = RWAIT;
            RWAIT: begin
                if (cnt_r == 2'd0) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = RWAIT;
                end
            end
            RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register, ready flag, strobes and read-latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            rd_en_r     <= 1'b0;
            wr_en_r     <= 1'b0;
            cnt_r       <= 2'd0;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == IDLE);
            rd_en_r     <= (state_next_s == RD);
            wr_en_r     <= (state_next_s == WR);
            if (state_r == RD) begin
                cnt_r <= 2'(READ_LATENCY - 1);
            end else if ((state_r == RWAIT) && (cnt_r != 2'd0)) begin
                cnt_r <= cnt_r - 2'd1;
            end
        end
    end

    // Request capture at accept and load-data capture at the end of RWAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            size_r      <= MEM_B;
            off_r       <= 2'd0;
            uns_r       <= 1'b0;
            err_r       <= 1'b0;
            rdata_cap_r <= 32'd0;
        end else if (accept_s) begin
            size_r      <= req_size_s;
            off_r       <= req_addr[1:0];
            uns_r       <= req_unsigned;
            err_r       <= req_err_s;
            rdata_cap_r <= 32'd0;
        end else if ((state_r == RWAIT) && (cnt_r == 2'd0)) begin
            rdata_cap_r <= ld_data_s;
        end
    end

    // SRAM address, lane enables and write data; held between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_sel_r <= '0;
            byte_sel_r <= 4'b0000;
            datain_r   <= 32'd0;
        end else if (accept_s && !req_err_s) begin
            addr_sel_r <= req_addr[ADDR_WIDTH+1:2];
            byte_sel_r <= req_we ? st_byte_sel_s : LANE_ALL;
            if (req_we) begin
                datain_r <= st_data_s;
            end
        end
    end

    // Response registers; data and error are forced to zero outside a valid response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
        end else begin
            rsp_valid_r <= rsp_valid_next_s;
            rsp_err_r   <= rsp_valid_next_s & err_r;
            rsp_rdata_r <= rsp_valid_next_s ? rdata_cap_r : 32'd0;
        end
    end

    assign req_ready         = req_ready_r;
    assign rsp_valid         = rsp_valid_r;
    assign rsp_err           = rsp_err_r;
    assign rsp_rdata         = rsp_rdata_r;
    assign sram_addr_sel     = addr_sel_r;
    assign sram_byte_sel     = byte_sel_r;
    assign sram_read_enable  = rd_en_r;
    assign sram_write_enable = wr_en_r;
    assign sram_datain       = datain_r;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Two controllers (read latency 1 and 2) run in lock-step against a byte-array memory model.
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_unsigned, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        req_ready_w [2];
    logic        rsp_valid_w [2];
    logic [31:0] rsp_rdata_w [2];
    logic        rsp_err_w   [2];
    logic [6:0]  sram_addr_w [2];
    logic [3:0]  sram_sel_w  [2];
    logic        sram_re_w   [2];
    logic        sram_we_w   [2];
    logic [31:0] sram_din_w  [2];

    logic [7:0]  ref_mem [512];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem [128];
        logic [31:0] stage;
        logic [31:0] dout;

        initial begin
            for (int w = 0; w < 128; w++) mem[w] = 32'd0;
        end

        // SRAM macro model: byte-enabled writes, reads valid READ_LATENCY cycles later, junk otherwise.
        always @(posedge clk) begin
            if (sram_we_w[g]) begin
                for (int j = 0; j < 4; j++) begin
                    if (sram_sel_w[g][j]) mem[sram_addr_w[g]][8*j +: 8] <= sram_din_w[g][8*j +: 8];
                end
            end
            stage <= sram_re_w[g] ? mem[sram_addr_w[g]] : $urandom;
            dout  <= (g == 0) ? (sram_re_w[g] ? mem[sram_addr_w[g]] : $urandom) : stage;
        end

        sram_access_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .READ_LATENCY(g + 1)) u_dut (
            .clk               (clk),
            .reset             (reset),
            .req_valid         (req_valid),
            .req_ready         (req_ready_w[g]),
            .req_we            (req_we),
            .req_addr          (req_addr),
            .req_size          (req_size),
            .req_unsigned      (req_unsigned),
            .req_wdata         (req_wdata),
            .rsp_valid         (rsp_valid_w[g]),
            .rsp_ready         (rsp_ready),
            .rsp_rdata         (rsp_rdata_w[g]),
            .rsp_err           (rsp_err_w[g]),
            .sram_addr_sel     (sram_addr_w[g]),
            .sram_byte_sel     (sram_sel_w[g]),
            .sram_read_enable  (sram_re_w[g]),
            .sram_write_enable (sram_we_w[g]),
            .sram_datain       (sram_din_w[g]),
            .sram_dataout      (dout)
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=0x%08h exp=0x%08h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] addr, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) ||
               (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'd512);
    endfunction

    task automatic check_all_zero(input int i);
        check_eq("zero_ctl", {16'd0, req_ready_w[i], rsp_valid_w[i], rsp_err_w[i], sram_re_w[i],
                              sram_we_w[i], sram_addr_w[i], sram_sel_w[i]}, 32'd0);
        check_eq("zero_rdata", rsp_rdata_w[i], 32'd0);
        check_eq("zero_datain", sram_din_w[i], 32'd0);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!(req_ready_w[0] && req_ready_w[1]) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("idle_ready", 32'(req_ready_w[0] & req_ready_w[1]), 32'd1);
    endtask

    // One transaction on both controllers; hold>0 keeps rsp_ready low that many extra cycles.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input int hold);
        int          nb, kmax;
        int          lat [2];
        int          hs [2];
        int          wcnt [2];
        int          rcnt [2];
        logic        err, exp_v;
        logic [31:0] exp_rd, exp_din;
        logic [3:0]  exp_sel;

        nb      = 1 << size;
        err     = ref_err(addr, size);
        exp_rd  = 32'd0;
        exp_din = 32'd0;
        exp_sel = 4'hF;
        if (!err && we) begin
            for (int b = 0; b < nb; b++) ref_mem[9'(addr + 32'(b))] = wdata[8*b +: 8];
            exp_sel = 4'(((1 << nb) - 1) << addr[1:0]);
            for (int j = 0; j < 4; j++) exp_din[8*j +: 8] = wdata[8*(j % nb) +: 8];
        end else if (!err) begin
            for (int b = 0; b < nb; b++) exp_rd = exp_rd | (32'(ref_mem[9'(addr + 32'(b))]) << (8*b));
            if (!uns && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | ~((32'd1 << (8*nb)) - 32'd1);
        end
        for (int i = 0; i < 2; i++) begin
            lat[i]  = err ? 1 : (we ? 2 : 3 + i);
            wcnt[i] = 0;
            rcnt[i] = 0;
        end
        for (int i = 0; i < 2; i++) hs[i] = (hold > 0) ? lat[1] + hold + 1 : lat[i] + 1;
        kmax = hs[1];

        wait_idle();
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        rsp_ready    = (hold == 0);
        for (int k = 0; k <= kmax; k++) begin
            @(negedge clk);
            if (k == 0) begin
                // While held, a competing store must not be sampled.
                req_valid = (hold > 0);
                req_we    = 1'b1;
                req_addr  = 32'd0;
                req_size  = 2'd2;
                req_wdata = 32'hBAD0BAD0;
            end
            for (int i = 0; i < 2; i++) begin
                exp_v = (k >= lat[i]) && (k < hs[i]);
                check_eq("rsp_valid", 32'(rsp_valid_w[i]), 32'(exp_v));
                if (exp_v) begin
                    check_eq("rsp_rdata", rsp_rdata_w[i], exp_rd);
                    check_eq("rsp_err", 32'(rsp_err_w[i]), 32'(err));
                end
                check_eq("req_ready", 32'(req_ready_w[i]), 32'(k >= hs[i]));
                if (sram_we_w[i] && sram_re_w[i]) check_eq("strobe_excl", 32'd1, 32'd0);
                if (sram_we_w[i]) begin
                    wcnt[i]++;
                    check_eq("wr_addr", 32'(sram_addr_w[i]), addr >> 2);
                    check_eq("wr_sel", 32'(sram_sel_w[i]), 32'(exp_sel));
                    check_eq("wr_din", sram_din_w[i], exp_din);
                end
                if (sram_re_w[i]) begin
                    rcnt[i]++;
                    check_eq("rd_addr", 32'(sram_addr_w[i]), addr >> 2);
                    check_eq("rd_sel", 32'(sram_sel_w[i]), 32'hF);
                end
            end
            if (hold > 0 && k == hs[1] - 1) rsp_ready = 1'b1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_eq("wr_strobes", 32'(wcnt[i]), 32'(we && !err));
            check_eq("rd_strobes", 32'(rcnt[i]), 32'(!we && !err));
        end
    endtask

    // Load interrupted by reset while both controllers sit in RWAIT.
    task automatic reset_mid();
        wait_idle();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h28;
        req_size  = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_eq("mid_busy", 32'(req_ready_w[i]), 32'd0);
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) check_all_zero(i);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_eq("post_rst_ready", 32'(req_ready_w[i]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          hold;

        for (int b = 0; b < 512; b++) ref_mem[b] = 8'd0;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) check_all_zero(i);
        reset = 1'b1;
        @(negedge clk);

        txn(1'b1, 32'h28, 2'd2, 1'b0, 32'hDEADBEEF, 0);
        txn(1'b0, 32'h28, 2'd2, 1'b0, 32'd0, 0);
        txn(1'b1, 32'h28, 2'd1, 1'b0, 32'h00005678, 0);
        txn(1'b0, 32'h28, 2'd2, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h2B, 2'd0, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h2B, 2'd0, 1'b1, 32'd0, 0);
        txn(1'b0, 32'h2A, 2'd1, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h29, 2'd2, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h2B, 2'd1, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h28, 2'd3, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h200, 2'd2, 1'b0, 32'd0, 0);
        txn(1'b1, 32'h30, 2'd0, 1'b0, 32'h000000AB, 0);
        txn(1'b0, 32'h28, 2'd2, 1'b0, 32'd0, 5);
        reset_mid();
        txn(1'b1, 32'h14, 2'd2, 1'b0, 32'hA5A5A5A5, 0);
        txn(1'b0, 32'h14, 2'd2, 1'b0, 32'd0, 0);

        for (int n = 0; n < 120; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            hold = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
